// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types for the I/D memory bus arbiter.
// The optional anti-starvation feature is enabled with the MEM_ARB_FAIR_EN macro.
package mem_bus_arbiter_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned CNT_W  = 4;

  localparam logic [1:0] SIZE_WORD = 2'b10;

  typedef enum logic [1:0] {ARB_IDLE, ARB_REQ, ARB_WAIT} arb_state_t;
  typedef enum logic [1:0] {OWN_NONE, OWN_I, OWN_D} arb_owner_t;

  typedef struct packed {
    logic              wr;
    logic [1:0]        size;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } mem_req_t;

  // Pipeline-facing stall view packed by the CPU top.
  typedef struct packed {
    logic imem_busy;
    logic dmem_busy;
  } busy_ok_t;

endpackage

// File: rtl/mem_arb_picker.sv
// Combinational I/D grant with D priority; with MEM_ARB_FAIR_EN defined, a
// starvation counter forces an I grant after STARVE_LIMIT consecutive D grants.
module mem_arb_picker
  import mem_bus_arbiter_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic i_arb_en,
  input  logic i_fetch_req,
  input  logic i_ls_req,
  output logic o_grant_i_c,
  output logic o_grant_d_c
);

`ifdef MEM_ARB_FAIR_EN
  logic [CNT_W-1:0] r_starve_cnt;
  logic             w_force_i;

  assign w_force_i   = (r_starve_cnt >= CNT_W'(STARVE_LIMIT));
  assign o_grant_i_c = i_arb_en && i_fetch_req && (!i_ls_req || w_force_i);
  assign o_grant_d_c = i_arb_en && i_ls_req && !o_grant_i_c;

  // Counts D grants that left a fetch waiting; any I grant or idle fetch side clears it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_starve_cnt <= '0;
    end else if (i_arb_en) begin
      if (!i_fetch_req || o_grant_i_c) begin
        r_starve_cnt <= '0;
      end else if (o_grant_d_c) begin
        r_starve_cnt <= r_starve_cnt + CNT_W'(1);
      end
    end
  end
`else
  logic w_unused;

  assign w_unused    = ^{clk, rst, CNT_W'(STARVE_LIMIT)};
  assign o_grant_i_c = i_arb_en && i_fetch_req && !i_ls_req;
  assign o_grant_d_c = i_arb_en && i_ls_req;
`endif

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares one SRAM-like bus between fetch (I) and load/store (D), one transaction at a time.
// Define MEM_ARB_FAIR_EN to bound how long D may starve a pending fetch.
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic [31:0] i_rdata,
  output logic        i_done,
  input  logic        d_req,
  input  logic        d_wr,
  input  logic [1:0]  d_size,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  output logic        d_done,
  output logic        bus_req,
  output logic        bus_wr,
  output logic [1:0]  bus_size,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic        bus_addr_ok,
  input  logic        bus_data_ok,
  input  logic [31:0] bus_rdata,
  output logic        imem_busy,
  output logic        dmem_busy
);

  arb_state_t r_state;
  arb_owner_t r_owner;
  mem_req_t   r_bus;
  logic       r_bus_req;

  logic       w_arb_en;
  logic       w_grant_i;
  logic       w_grant_d;
  logic       w_data_done;
  mem_req_t   w_i_fields;
  mem_req_t   w_d_fields;

  assign w_arb_en = (r_state == ARB_IDLE);

  mem_arb_picker #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_picker (
    .clk        (clk),
    .rst        (rst),
    .i_arb_en   (w_arb_en),
    .i_fetch_req(i_req),
    .i_ls_req   (d_req),
    .o_grant_i_c(w_grant_i),
    .o_grant_d_c(w_grant_d)
  );

  // Candidate bus payloads; fetch is always a word read.
  always_comb begin
    w_i_fields       = '0;
    w_i_fields.size  = SIZE_WORD;
    w_i_fields.addr  = i_addr;
    w_d_fields.wr    = d_wr;
    w_d_fields.size  = d_size;
    w_d_fields.addr  = d_addr;
    w_d_fields.wdata = d_wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ARB_IDLE;
      r_owner   <= OWN_NONE;
      r_bus     <= '0;
      r_bus_req <= 1'b0;
    end else begin
      case (r_state)
        ARB_IDLE: begin
          if (w_grant_d) begin
            r_owner   <= OWN_D;
            r_bus     <= w_d_fields;
            r_bus_req <= 1'b1;
            r_state   <= ARB_REQ;
          end else if (w_grant_i) begin
            r_owner   <= OWN_I;
            r_bus     <= w_i_fields;
            r_bus_req <= 1'b1;
            r_state   <= ARB_REQ;
          end
        end
        ARB_REQ: begin
          if (bus_addr_ok) begin
            r_bus_req <= 1'b0;
            r_bus     <= '0;
            r_state   <= ARB_WAIT;
          end
        end
        ARB_WAIT: begin
          if (bus_data_ok) begin
            r_owner <= OWN_NONE;
            r_state <= ARB_IDLE;
          end
        end
        default: begin
          r_owner   <= OWN_NONE;
          r_bus_req <= 1'b0;
          r_state   <= ARB_IDLE;
        end
      endcase
    end
  end

  // Completion is steered to the owner in the data-phase cycle so stalls release without delay.
  assign w_data_done = (r_state == ARB_WAIT) && bus_data_ok;
  assign i_done      = w_data_done && (r_owner == OWN_I);
  assign d_done      = w_data_done && (r_owner == OWN_D);
  assign i_rdata     = i_done ? bus_rdata : '0;
  assign d_rdata     = d_done ? bus_rdata : '0;

  assign imem_busy = i_req && !i_done;
  assign dmem_busy = d_req && !d_done;

  assign bus_req   = r_bus_req;
  assign bus_wr    = r_bus.wr;
  assign bus_size  = r_bus.size;
  assign bus_addr  = r_bus.addr;
  assign bus_wdata = r_bus.wdata;

  a_no_early_data: assert property (@(posedge clk) disable iff (rst)
    !((r_state == ARB_REQ) && bus_data_ok));

  a_i_req_held: assert property (@(posedge clk) disable iff (rst)
    ((r_state != ARB_IDLE) && (r_owner == OWN_I)) |-> i_req);

  a_d_req_held: assert property (@(posedge clk) disable iff (rst)
    ((r_state != ARB_IDLE) && (r_owner == OWN_D)) |-> d_req);

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: directed scenarios plus random traffic
// against a transaction-level arbitration model (honours MEM_ARB_FAIR_EN).
module tb_mem_bus_arbiter;
  import mem_bus_arbiter_pkg::*;

  localparam int unsigned LIMIT = 2;
`ifdef MEM_ARB_FAIR_EN
  localparam bit FAIR = 1'b1;
`else
  localparam bit FAIR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        i_req;
  logic [31:0] i_addr;
  logic [31:0] i_rdata;
  logic        i_done;
  logic        d_req;
  logic        d_wr;
  logic [1:0]  d_size;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [31:0] d_rdata;
  logic        d_done;
  logic        bus_req;
  logic        bus_wr;
  logic [1:0]  bus_size;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic        bus_addr_ok;
  logic        bus_data_ok;
  logic [31:0] bus_rdata;
  logic        imem_busy;
  logic        dmem_busy;

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int d_streak;
  bit drop_i, drop_d;
  bit hold_both, raise_rand;
  int order[$];

  mem_bus_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_done(i_done),
    .d_req(d_req), .d_wr(d_wr), .d_size(d_size), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_done(d_done),
    .bus_req(bus_req), .bus_wr(bus_wr), .bus_size(bus_size), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_addr_ok(bus_addr_ok), .bus_data_ok(bus_data_ok),
    .bus_rdata(bus_rdata), .imem_busy(imem_busy), .dmem_busy(dmem_busy)
  );

  initial forever #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic chk_outs(input logic e_breq, input logic e_idone, input logic e_ddone,
                          input logic [31:0] rd);
    chk("bus_req", 32'(bus_req), 32'(e_breq));
    chk("i_done", 32'(i_done), 32'(e_idone));
    chk("d_done", 32'(d_done), 32'(e_ddone));
    chk("i_rdata", i_rdata, e_idone ? rd : 32'h0);
    chk("d_rdata", d_rdata, e_ddone ? rd : 32'h0);
    chk("imem_busy", 32'(imem_busy), 32'(i_req && !e_idone));
    chk("dmem_busy", 32'(dmem_busy), 32'(d_req && !e_ddone));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (drop_i) begin i_req = 1'b0; drop_i = 1'b0; end
    if (drop_d) begin d_req = 1'b0; drop_d = 1'b0; end
    bus_addr_ok = 1'b0;
    bus_data_ok = 1'b0;
    bus_rdata   = $urandom();
  endtask

  task automatic new_i();
    i_req  = 1'b1;
    i_addr = $urandom() & 32'hFFFF_FFFC;
  endtask

  task automatic new_d();
    d_req   = 1'b1;
    d_wr    = 1'($urandom_range(0, 1));
    d_size  = 2'($urandom_range(0, 2));
    d_addr  = $urandom();
    d_wdata = $urandom();
  endtask

  // Arbitration cycle: D first unless a fetch has waited through LIMIT D grants (fair build).
  task automatic arb_eval(output int owner);
    #1;
    chk_outs(1'b0, 1'b0, 1'b0, 32'h0);
    owner = 0;
    if (i_req && (!d_req || (FAIR && d_streak == int'(LIMIT)))) owner = 1;
    else if (d_req) owner = 2;
    if (owner == 1 || !i_req) d_streak = 0;
    else if (owner == 2) d_streak++;
  endtask

  task automatic xact(input int owner, input int a, input int b, input logic [31:0] rd);
    logic        e_wr;
    logic [1:0]  e_size;
    logic [31:0] e_addr, e_wdata;
    logic        fin;
    e_wr    = (owner == 2) ? d_wr : 1'b0;
    e_size  = (owner == 2) ? d_size : SIZE_WORD;
    e_addr  = (owner == 2) ? d_addr : i_addr;
    e_wdata = d_wdata;
    for (int j = 0; j <= a; j++) begin
      tick();
      bus_addr_ok = (j == a);
      #1;
      chk_outs(1'b1, 1'b0, 1'b0, 32'h0);
      chk("bus_wr", 32'(bus_wr), 32'(e_wr));
      chk("bus_size", 32'(bus_size), 32'(e_size));
      chk("bus_addr", bus_addr, e_addr);
      if (e_wr) chk("bus_wdata", bus_wdata, e_wdata);
    end
    for (int j = 0; j <= b; j++) begin
      tick();
      fin = (j == b);
      if (fin) begin
        bus_data_ok = 1'b1;
        bus_rdata   = rd;
      end
      #1;
      chk_outs(1'b0, fin && owner == 1, fin && owner == 2, rd);
      if (fin) order.push_back(d_done ? 2 : (i_done ? 1 : 0));
    end
    if (owner == 1) drop_i = 1'b1;
    else drop_d = 1'b1;
  endtask

  initial begin
    int o;
    rst = 1'b1;
    {i_req, d_req, d_wr, bus_addr_ok, bus_data_ok} = '0;
    d_size = '0; i_addr = '0; d_addr = '0; d_wdata = '0; bus_rdata = '0;
    d_streak = 0; drop_i = 0; drop_d = 0; hold_both = 0; raise_rand = 0;

    // Reset: outputs quiet, busy still follows the request inputs
    #2;
    chk_outs(1'b0, 1'b0, 1'b0, 32'h0);
    i_req = 1'b1;
    #1;
    chk_outs(1'b0, 1'b0, 1'b0, 32'h0);
    chk("rst_bus_fields", {bus_wr, bus_size, bus_addr[28:0]} | bus_wdata, 32'h0);
    i_req = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;

    // 1: fetch alone, minimum latency
    tick(); i_req = 1'b1; i_addr = 32'hBFC0_0000; arb_eval(o);
    xact(o, 0, 0, 32'h3C08_0001);

    // 2: simultaneous fetch and load, D first
    tick(); new_i(); d_req = 1'b1; d_wr = 1'b0; d_size = 2'd2; d_addr = 32'h8000_1000;
    arb_eval(o); xact(o, 0, 0, $urandom());
    tick(); arb_eval(o); xact(o, 0, 0, $urandom());

    // 3: byte store held through a slow address phase
    tick(); d_req = 1'b1; d_wr = 1'b1; d_size = 2'd0; d_addr = $urandom(); d_wdata = 32'hDEAD_BEEF;
    arb_eval(o); xact(o, 4, 1, $urandom());

    // 4: reset during the data wait abandons the transaction
    tick(); new_i(); arb_eval(o);
    tick(); bus_addr_ok = 1'b1; #1;
    chk_outs(1'b1, 1'b0, 1'b0, 32'h0);
    tick(); bus_data_ok = 1'b1; rst = 1'b1; i_req = 1'b0; #1;
    chk_outs(1'b0, 1'b0, 1'b0, 32'h0);
    chk("state_after_rst", 32'(dut.r_state), 32'(ARB_IDLE));
    tick(); rst = 1'b0; d_streak = 0; arb_eval(o);
    tick(); new_d(); arb_eval(o); xact(o, 1, 0, $urandom());

    // 5: both requesters saturate the bus
    order.delete();
    hold_both = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (!i_req) new_i();
      if (!d_req) new_d();
      arb_eval(o);
      xact(o, $urandom_range(0, 2), $urandom_range(0, 2), $urandom());
    end
    hold_both = 1'b0;
    for (int k = 0; k < 6; k++) begin
      int e;
      e = (FAIR && (k % 3 == 2)) ? 1 : 2;
      chk($sformatf("grant_order[%0d]", k), (k < order.size()) ? 32'(order[k]) : 32'hFFFF_FFFF, 32'(e));
    end

    // Random traffic
    raise_rand = 1'b1;
    for (int k = 0; k < 200; k++) begin
      tick();
      if (!i_req && $urandom_range(0, 1) == 1) new_i();
      if (!d_req && $urandom_range(0, 1) == 1) new_d();
      arb_eval(o);
      if (o != 0) xact(o, $urandom_range(0, 3), $urandom_range(0, 3), $urandom());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
